alu_wide_sequencer: RTL

//  Initiator side of the N-bit ALU port: drives enable/mode/in_a/in_b and consumes out/flag_zero/flag_carry.

---
 rtl/alu_wide_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_wide_sequencer.sv
// Wide-operand sequencer for an N-bit ALU slice.
// Splits a WORDS*N-bit operation into N-bit slices issued LS slice first,
// chaining carry through the ALU's own carry flag, and reassembles the result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; operands latched on accept
// S_RUN   | one slice issued to the ALU per cycle (alu_enable high)
// S_DRAIN | ALU idle; last slice and wide carry captured, done raised
// S_FAULT | illegal op accepted; reports err one edge later, ALU untouched
// S_DONE  | done pulse visible; returns to S_IDLE
module alu_wide_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4,
  // ALU mode encodings; override to match the attached alu's parameter set
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_ADC = 3'd1,
  parameter logic [2:0] ALU_INC = 3'd2,
  parameter logic [2:0] ALU_AND = 3'd3,
  parameter logic [2:0] ALU_OR  = 3'd4,
  parameter logic [2:0] ALU_XOR = 3'd5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 alu_enable,
  output logic [2:0]           alu_mode,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  input  logic [N-1:0]         alu_out,
  input  logic                 alu_flag_zero,
  input  logic                 alu_flag_carry
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FAULT, S_DONE} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nx;
  logic          cap_en;
  logic [IW-1:0] cap_idx;
  logic [W-1:0]  res_cap;

  // zero is derived from the captured wide result, not the per-slice flag
  logic unused_flag_zero;
  assign unused_flag_zero = alu_flag_zero;

  // first slice of ADD/INC seeds the chain; every later slice adds the ALU carry
  function automatic logic [2:0] slice_mode(input logic [2:0] o, input logic first);
    case (o)
      OP_ADD:  slice_mode = first ? ALU_ADD : ALU_ADC;
      OP_ADC:  slice_mode = ALU_ADC;
      OP_INC:  slice_mode = first ? ALU_INC : ALU_ADC;
      OP_AND:  slice_mode = ALU_AND;
      OP_OR:   slice_mode = ALU_OR;
      OP_XOR:  slice_mode = ALU_XOR;
      default: slice_mode = ALU_ADD;
    endcase
  endfunction

  assign idx_nx = idx + 1'b1;

  // result with the ALU's current output merged into the slice it belongs to
  always_comb begin
    res_cap = result;
    res_cap[cap_idx*N +: N] = alu_out;
  end

  // sequencing FSM, slice capture and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      cap_en     <= 1'b0;
      cap_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      alu_enable <= 1'b0;
      alu_mode   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      // the ALU output of an enabled edge is valid for exactly one cycle
      cap_en  <= alu_enable;
      cap_idx <= idx;
      if (cap_en) result <= res_cap;
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= op_a;
            b_q  <= op_b;
            idx  <= '0;
            busy <= 1'b1;
            err  <= 1'b0;
            if (op <= OP_XOR) begin
              state      <= S_RUN;
              alu_enable <= 1'b1;
              alu_mode   <= slice_mode(op, 1'b1);
              alu_a      <= op_a[N-1:0];
              alu_b      <= (op == OP_INC) ? '0 : op_b[N-1:0];
            end else begin
              state <= S_FAULT;
            end
          end
        end
        S_RUN: begin
          if (idx == LAST) begin
            alu_enable <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            idx      <= idx_nx;
            alu_mode <= slice_mode(op_q, 1'b0);
            alu_a    <= a_q[idx_nx*N +: N];
            alu_b    <= (op_q == OP_INC) ? '0 : b_q[idx_nx*N +: N];
          end
        end
        S_DRAIN: begin
          carry <= (op_q <= OP_INC) ? alu_flag_carry : 1'b0;
          zero  <= (res_cap == '0);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_FAULT: begin
          err   <= 1'b1;
          carry <= 1'b0;
          zero  <= (result == '0);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
